// File: rtl/reset_gen_pkg.sv
// Shared types and default timing constants for the staggered reset generator.
// Sequencer states, default hold/stagger/debounce lengths, and the domain-count ceiling.
package reset_gen_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } rg_state_t;

   localparam int HOLD_CYC_DEF    = 1024;
   localparam int STAGGER_CYC_DEF = 16;
   localparam int DEB_CYC_DEF     = 255;
   localparam int N_DOM_MAX       = 8;
   // Wide enough to index any of the N_DOM_MAX domains.
   localparam int IDX_W           = 3;

endpackage

// File: rtl/rst_btn_debounce.sv
// Pushbutton front end: 2-flop synchronizer, saturating low-sample counter, one-shot press pulse.
// press_vld is high for one cycle on the edge of the DEB_CYC-th consecutive low synced sample.
module rst_btn_debounce
   import reset_gen_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEF
) (
   input  logic clk,
   input  logic arst_n,
   input  logic btn_n,
   output logic press_vld
);

   localparam int DW = $clog2(DEB_CYC + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   always_comb begin
      sync1_d = btn_n;
      sync2_d = sync1_q;
      cnt_d   = '0;
      press_d = 1'b0;
      // Saturation at DEB_CYC keeps a held button from producing a second event.
      if (!sync2_q) begin
         if (cnt_q != DW'(DEB_CYC)) begin
            cnt_d = cnt_q + DW'(1);
         end else begin
            cnt_d = cnt_q;
         end
         press_d = (cnt_q == DW'(DEB_CYC - 1));
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_vld = press_q;

endmodule

// File: rtl/reset_gen.sv
// Staggered active-low reset sequencer: immediate assertion of all domains, held release in ascending order.
// Pushbutton reset path present only when RESET_GEN_BTN_EN is defined; otherwise btn_n is ignored.
module reset_gen
   import reset_gen_pkg::*;
#(
   parameter int N_DOM       = 3,
   parameter int HOLD_CYC    = HOLD_CYC_DEF,
   parameter int STAGGER_CYC = STAGGER_CYC_DEF,
   parameter int DEB_CYC     = DEB_CYC_DEF,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             btn_n,
   input  logic             sw_req,
   output logic             sw_ack,
   output logic [N_DOM-1:0] dom_rst_n,
   output logic             all_released
);

   rg_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N_DOM-1:0] dom_rst_n_q, dom_rst_n_d;
   logic             all_released_q, all_released_d;
   logic             sw_ack_q, sw_ack_d;
   logic             press_vld;

`ifdef RESET_GEN_BTN_EN
   rst_btn_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_btn_debounce (
      .clk       (clk),
      .arst_n    (arst_n),
      .btn_n     (btn_n),
      .press_vld (press_vld)
   );
`else
   localparam int unused_deb_cyc = DEB_CYC;
   logic unused_btn_n;
   assign unused_btn_n = btn_n;
   assign press_vld    = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      dom_rst_n_d    = dom_rst_n_q;
      all_released_d = all_released_q;
      sw_ack_d       = 1'b0;

      case (state_q)
         ST_ASSERT: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
               cnt_d          = '0;
               dom_rst_n_d[0] = 1'b1;
               if (N_DOM == 1) begin
                  state_d        = ST_RUN;
                  all_released_d = 1'b1;
               end else begin
                  state_d = ST_RELEASE;
                  idx_d   = IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            if (cnt_q == CNT_W'(STAGGER_CYC - 1)) begin
               cnt_d = '0;
               for (int i = 0; i < N_DOM; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     dom_rst_n_d[i] = 1'b1;
                  end
               end
               if (idx_q == IDX_W'(N_DOM - 1)) begin
                  state_d        = ST_RUN;
                  all_released_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            // Requests seen earlier stay pending on sw_req and are taken here.
            if (sw_req) begin
               sw_ack_d = 1'b1;
               state_d  = ST_ASSERT;
            end
         end
         default: begin
            state_d = ST_ASSERT;
         end
      endcase

      // A button press restarts the sequence from any point past ASSERT.
      if (press_vld && (state_q != ST_ASSERT)) begin
         state_d = ST_ASSERT;
      end

      if (state_d == ST_ASSERT) begin
         cnt_d          = '0;
         idx_d          = '0;
         dom_rst_n_d    = '0;
         all_released_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q        <= ST_ASSERT;
         cnt_q          <= '0;
         idx_q          <= '0;
         dom_rst_n_q    <= '0;
         all_released_q <= 1'b0;
         sw_ack_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         dom_rst_n_q    <= dom_rst_n_d;
         all_released_q <= all_released_d;
         sw_ack_q       <= sw_ack_d;
      end
   end

   assign dom_rst_n    = dom_rst_n_q;
   assign all_released = all_released_q;
   assign sw_ack       = sw_ack_q;

endmodule

// File: tb/tb_reset_gen.sv
// Directed bench for reset_gen: power-up, software reset, async and button restarts, N_DOM=1 corner.
`timescale 1ns/1ps
module tb_reset_gen;
   import reset_gen_pkg::*;

   localparam int HOLD = 4;
   localparam int STAG = 2;
   localparam int NDOM = 3;
   localparam int DEB  = 8;
`ifdef RESET_GEN_BTN_EN
   localparam bit BTN = 1'b1;
`else
   localparam bit BTN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       arst_n, btn_n, sw_req, sw_ack, all_released;
   logic [2:0] dom_rst_n;
   logic       arst_n_b, sw_ack_b, all_released_b;
   logic       btn_n_b  = 1'b1;
   logic       sw_req_b = 1'b0;
   logic [0:0] dom_rst_n_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reset_gen #(.N_DOM(NDOM), .HOLD_CYC(HOLD), .STAGGER_CYC(STAG), .DEB_CYC(DEB), .CNT_W(8)) dut_a (
      .clk(clk), .arst_n(arst_n), .btn_n(btn_n), .sw_req(sw_req),
      .sw_ack(sw_ack), .dom_rst_n(dom_rst_n), .all_released(all_released));

   reset_gen #(.N_DOM(1), .HOLD_CYC(1), .STAGGER_CYC(2), .DEB_CYC(DEB), .CNT_W(4)) dut_b (
      .clk(clk), .arst_n(arst_n_b), .btn_n(btn_n_b), .sw_req(sw_req_b),
      .sw_ack(sw_ack_b), .dom_rst_n(dom_rst_n_b), .all_released(all_released_b));

   // Expected domain mask k edges after the edge that entered ASSERT.
   function automatic logic [2:0] exp_dom(input int k);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < NDOM; i++) begin
         if (k >= 1 + HOLD + i * STAG) r[i] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic exp_all(input int k);
      return (k >= 1 + HOLD + (NDOM - 1) * STAG);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst_n = 1'b1; arst_n_b = 1'b1; btn_n = 1'b1; sw_req = 1'b0;
      #2;
      arst_n = 1'b0; arst_n_b = 1'b0;
      #1;
      checks++; if (dom_rst_n !== 3'b000) begin failures++; $display("FAIL reset_dom got=%b exp=000", dom_rst_n); end
      checks++; if (all_released !== 1'b0) begin failures++; $display("FAIL reset_all got=%b exp=0", all_released); end
      checks++; if (sw_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", sw_ack); end
      checks++; if (dom_rst_n_b !== 1'b0) begin failures++; $display("FAIL reset_dom_b got=%b exp=0", dom_rst_n_b); end
      repeat (3) tick();
      checks++; if (dom_rst_n !== 3'b000) begin failures++; $display("FAIL reset_hold_dom got=%b exp=000", dom_rst_n); end
      checks++; if (all_released_b !== 1'b0) begin failures++; $display("FAIL reset_hold_all_b got=%b exp=0", all_released_b); end
   endtask

   task automatic test_n1();
      arst_n_b = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (dom_rst_n_b !== 1'(k >= 2)) begin failures++; $display("FAIL n1_dom k=%0d got=%b exp=%b", k, dom_rst_n_b, k >= 2); end
         checks++; if (all_released_b !== (k >= 2)) begin failures++; $display("FAIL n1_all k=%0d got=%b exp=%b", k, all_released_b, k >= 2); end
         checks++; if (dut_b.state_q === ST_RELEASE) begin failures++; $display("FAIL n1_no_release k=%0d got=RELEASE exp=not RELEASE", k); end
      end
   endtask

   task automatic test_power_up();
      arst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++; if (dom_rst_n !== exp_dom(k)) begin failures++; $display("FAIL pu_dom k=%0d got=%b exp=%b", k, dom_rst_n, exp_dom(k)); end
         checks++; if (all_released !== exp_all(k)) begin failures++; $display("FAIL pu_all k=%0d got=%b exp=%b", k, all_released, exp_all(k)); end
      end
   endtask

   task automatic test_sw_reset();
      sw_req = 1'b1;
      tick();
      checks++; if (sw_ack !== 1'b1) begin failures++; $display("FAIL sw_ack_e0 got=%b exp=1", sw_ack); end
      checks++; if (dom_rst_n !== 3'b000) begin failures++; $display("FAIL sw_dom_e0 got=%b exp=000", dom_rst_n); end
      checks++; if (all_released !== 1'b0) begin failures++; $display("FAIL sw_all_e0 got=%b exp=0", all_released); end
      for (int k = 1; k <= 9; k++) begin
         tick();
         checks++; if (dom_rst_n !== exp_dom(k)) begin failures++; $display("FAIL sw_dom k=%0d got=%b exp=%b", k, dom_rst_n, exp_dom(k)); end
         checks++; if (sw_ack !== 1'b0) begin failures++; $display("FAIL sw_no_reack k=%0d got=%b exp=0", k, sw_ack); end
      end
      tick();
      checks++; if (sw_ack !== 1'b1) begin failures++; $display("FAIL sw_reack_run got=%b exp=1", sw_ack); end
      checks++; if (dom_rst_n !== 3'b000) begin failures++; $display("FAIL sw_reack_dom got=%b exp=000", dom_rst_n); end
      sw_req = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++; if (dom_rst_n !== exp_dom(k)) begin failures++; $display("FAIL sw2_dom k=%0d got=%b exp=%b", k, dom_rst_n, exp_dom(k)); end
         checks++; if (all_released !== exp_all(k)) begin failures++; $display("FAIL sw2_all k=%0d got=%b exp=%b", k, all_released, exp_all(k)); end
         checks++; if (sw_ack !== 1'b0) begin failures++; $display("FAIL sw2_ack k=%0d got=%b exp=0", k, sw_ack); end
      end
   endtask

   task automatic test_async_mid();
      #2 arst_n = 1'b0;
      #1;
      checks++; if (all_released !== 1'b0) begin failures++; $display("FAIL async_run_all got=%b exp=0", all_released); end
      checks++; if (dom_rst_n !== 3'b000) begin failures++; $display("FAIL async_run_dom got=%b exp=000", dom_rst_n); end
      tick();
      arst_n = 1'b1;
      for (int k = 1; k <= 6; k++) tick();
      checks++; if (dom_rst_n !== 3'b001) begin failures++; $display("FAIL async_pre_dom got=%b exp=001", dom_rst_n); end
      #2 arst_n = 1'b0;
      #1;
      checks++; if (dom_rst_n !== 3'b000) begin failures++; $display("FAIL async_rel_dom got=%b exp=000", dom_rst_n); end
      checks++; if (all_released !== 1'b0) begin failures++; $display("FAIL async_rel_all got=%b exp=0", all_released); end
      tick();
      arst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++; if (dom_rst_n !== exp_dom(k)) begin failures++; $display("FAIL async_re_dom k=%0d got=%b exp=%b", k, dom_rst_n, exp_dom(k)); end
      end
   endtask

   task automatic test_restart_mid();
      int r;
      btn_n = 1'b0;
      repeat (4) tick();
      sw_req = 1'b1;
      tick();
      checks++; if (sw_ack !== 1'b1) begin failures++; $display("FAIL rm_ack got=%b exp=1", sw_ack); end
      sw_req = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         r = (BTN && k >= 6) ? k - 6 : k;
         checks++; if (dom_rst_n !== exp_dom(r)) begin failures++; $display("FAIL rm_dom k=%0d got=%b exp=%b", k, dom_rst_n, exp_dom(r)); end
         checks++; if (all_released !== exp_all(r)) begin failures++; $display("FAIL rm_all k=%0d got=%b exp=%b", k, all_released, exp_all(r)); end
      end
      btn_n = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_bounce();
      for (int g = 1; g <= 7; g++) begin
         btn_n = 1'b0;
         repeat (g) tick();
         btn_n = 1'b1;
         for (int j = 0; j < 12; j++) begin
            tick();
            checks++; if (dom_rst_n !== 3'b111) begin failures++; $display("FAIL bounce_dom g=%0d got=%b exp=111", g, dom_rst_n); end
         end
      end
   endtask

   task automatic test_hold_20();
      int falls;
      logic [2:0] prev;
      falls = 0;
      prev  = dom_rst_n;
      btn_n = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 21) btn_n = 1'b1;
         tick();
         if (dom_rst_n == 3'b000 && prev != 3'b000) falls++;
         prev = dom_rst_n;
         if (k == 10 || k == 11) begin
            checks++;
            if (dom_rst_n !== ((BTN && k == 11) ? 3'b000 : 3'b111)) begin
               failures++; $display("FAIL hold_edge k=%0d got=%b exp=%b", k, dom_rst_n, (BTN && k == 11) ? 3'b000 : 3'b111);
            end
         end
      end
      checks++; if (falls !== (BTN ? 1 : 0)) begin failures++; $display("FAIL hold_events got=%0d exp=%0d", falls, BTN ? 1 : 0); end
      checks++; if (all_released !== 1'b1) begin failures++; $display("FAIL hold_end_all got=%b exp=1", all_released); end
   endtask

   task automatic test_btn_and_sw();
      btn_n = 1'b0;
      repeat (10) tick();
      sw_req = 1'b1;
      tick();
      checks++; if (sw_ack !== 1'b1) begin failures++; $display("FAIL both_ack got=%b exp=1", sw_ack); end
      checks++; if (dom_rst_n !== 3'b000) begin failures++; $display("FAIL both_dom got=%b exp=000", dom_rst_n); end
      sw_req = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         checks++; if (dom_rst_n !== exp_dom(k)) begin failures++; $display("FAIL both_sched k=%0d got=%b exp=%b", k, dom_rst_n, exp_dom(k)); end
         checks++; if (sw_ack !== 1'b0) begin failures++; $display("FAIL both_single_ack k=%0d got=%b exp=0", k, sw_ack); end
      end
      btn_n = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      test_reset();
      test_n1();
      test_power_up();
      test_sw_reset();
      test_async_mid();
      test_restart_mid();
      test_bounce();
      test_hold_20();
      test_btn_and_sw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
